// File: rtl/seq_divider_pkg.sv
// Shared ALU package for the iterative divider.
// Contents: FSM state encoding and width-parameterised special-case
// constants (all-ones quotient, signed minimum pattern).
package seq_divider_pkg;

    // Widest operand the constant helpers support.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // All-ones pattern of w bits, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] all_ones(input int unsigned w);
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // Two's-complement minimum (100...0) of w bits, zero-extended to MAX_W.
    function automatic logic [MAX_W-1:0] signed_min(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   p       partial remainder (WIDTH+1 bits)
//   bit_in  next dividend bit shifted into the remainder
//   divisor divisor magnitude
//   p_next  updated partial remainder
//   q_bit   quotient bit produced by this step
module seq_divider_div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   p,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] wide;
    logic             fits;

    // Trial subtraction: keep the difference only when it does not go negative.
    always_comb begin
        wide   = {p, bit_in};
        fits   = (wide >= (WIDTH+2)'(divisor));
        q_bit  = fits;
        p_next = fits ? (WIDTH+1)'(wide - (WIDTH+2)'(divisor))
                      : (WIDTH+1)'(wide);
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   start          request, accepted in IDLE or DONE
//   SIGNED, A, B   operand mode, dividend, divisor (sampled with start)
//   Q, R           registered quotient / remainder, updated at completion
//   busy, done     operation in progress / one-cycle completion pulse
//   DZ, V          divide-by-zero and signed-overflow flags of last operation
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             DZ,
    output logic             V
);

    localparam int unsigned     CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONES    = WIDTH'(all_ones(WIDTH));
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(signed_min(WIDTH));

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;      // dividend magnitude, quotient bits shift in from the right
    logic [WIDTH-1:0] dsr;      // divisor magnitude
    logic [WIDTH-1:0] a_raw;    // original dividend, returned as remainder on divide-by-zero
    logic [WIDTH:0]   p;
    logic             sign_q;
    logic             sign_r;
    logic             spec_dz;
    logic             spec_v;

    logic [WIDTH:0]   p_next;
    logic             q_bit;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic [WIDTH-1:0] q_fin_c;
    logic [WIDTH-1:0] r_fin_c;

    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .p       (p),
        .bit_in  (dvd[WIDTH-1]),
        .divisor (dsr),
        .p_next  (p_next),
        .q_bit   (q_bit)
    );

    // Operand magnitudes at load and sign fixup of the final step's result.
    always_comb begin
        mag_a_c = (SIGNED && A[WIDTH-1]) ? -A : A;
        mag_b_c = (SIGNED && B[WIDTH-1]) ? -B : B;
        q_fin_c = {dvd[WIDTH-2:0], q_bit};
        r_fin_c = p_next[WIDTH-1:0];
        if (sign_q) q_fin_c = -q_fin_c;
        if (sign_r) r_fin_c = -r_fin_c;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            dvd     <= '0;
            dsr     <= '0;
            a_raw   <= '0;
            p       <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            spec_dz <= 1'b0;
            spec_v  <= 1'b0;
            Q       <= '0;
            R       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            DZ      <= 1'b0;
            V       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_raw   <= A;
                        dvd     <= mag_a_c;
                        dsr     <= mag_b_c;
                        p       <= '0;
                        count   <= CW'(WIDTH - 1);
                        sign_q  <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
                        sign_r  <= SIGNED & A[WIDTH-1];
                        spec_dz <= (B == '0);
                        spec_v  <= SIGNED && (A == MIN_VAL) && (B == ONES);
                        DZ      <= 1'b0;
                        V       <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (spec_dz) begin
                        Q     <= ONES;
                        R     <= a_raw;
                        DZ    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (spec_v) begin
                        Q     <= a_raw;
                        R     <= '0;
                        V     <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        p     <= p_next;
                        dvd   <= {dvd[WIDTH-2:0], q_bit};
                        count <= count - CW'(1);
                        if (count == '0) begin
                            Q     <= q_fin_c;
                            R     <= r_fin_c;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 8).
module tb_seq_divider;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sgn = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             dz;
    logic             v;

    int checks = 0;
    int errors = 0;
    int n;
    int busy_cnt;

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .SIGNED (sgn),
        .A      (a),
        .B      (b),
        .Q      (q),
        .R      (r),
        .busy   (busy),
        .done   (done),
        .DZ     (dz),
        .V      (v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; start is seen by the next edge (edge 0).
    task automatic issue(input logic s, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
        sgn   = s;
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(q), 32'h00);
        check("rst_r", 32'(r), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_dz", 32'(dz), 32'h0);
        check("rst_v", 32'(v), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned 100 / 7, with busy duration
        issue(1'b0, 8'd100, 8'd7);
        check("u100_busy0", 32'(busy), 32'h1);
        busy_cnt = 1;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy === 1'b1) busy_cnt++;
        end
        check("u100_lat", 32'(n), 32'd8);
        check("u100_busycnt", 32'(busy_cnt), 32'd8);
        check("u100_q", 32'(q), 32'd14);
        check("u100_r", 32'(r), 32'd2);
        check("u100_dz", 32'(dz), 32'h0);
        check("u100_v", 32'(v), 32'h0);
        @(posedge clk);
        #1;
        check("u100_done_drop", 32'(done), 32'h0);

        // Unsigned 200 / 0
        issue(1'b0, 8'd200, 8'd0);
        wait_done(n);
        check("dz_lat", 32'(n), 32'd1);
        check("dz_q", 32'(q), 32'hFF);
        check("dz_r", 32'(r), 32'hC8);
        check("dz_flag", 32'(dz), 32'h1);
        check("dz_v", 32'(v), 32'h0);
        @(posedge clk);
        #1;

        // Signed -7 / 2; Q must hold its old value during RUN, DZ cleared on start
        issue(1'b1, 8'hF9, 8'h02);
        check("s1_dz_clr", 32'(dz), 32'h0);
        check("s1_q_hold", 32'(q), 32'hFF);
        wait_done(n);
        check("s1_lat", 32'(n), 32'd8);
        check("s1_q", 32'(q), 32'hFD);
        check("s1_r", 32'(r), 32'hFF);
        @(posedge clk);
        #1;

        // Signed 7 / -2
        issue(1'b1, 8'h07, 8'hFE);
        wait_done(n);
        check("s2_q", 32'(q), 32'hFD);
        check("s2_r", 32'(r), 32'h01);
        @(posedge clk);
        #1;

        // Signed MIN / -1
        issue(1'b1, 8'h80, 8'hFF);
        wait_done(n);
        check("ov_lat", 32'(n), 32'd1);
        check("ov_q", 32'(q), 32'h80);
        check("ov_r", 32'(r), 32'h00);
        check("ov_v", 32'(v), 32'h1);
        check("ov_dz", 32'(dz), 32'h0);
        @(posedge clk);
        #1;

        // Same operands unsigned: 128 / 255
        issue(1'b0, 8'h80, 8'hFF);
        wait_done(n);
        check("u128_lat", 32'(n), 32'd8);
        check("u128_q", 32'(q), 32'h00);
        check("u128_r", 32'(r), 32'h80);
        check("u128_v", 32'(v), 32'h0);
        @(posedge clk);
        #1;

        // Start while busy is ignored
        issue(1'b0, 8'd100, 8'd7);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        sgn   = 1'b1;
        a     = 8'd50;
        b     = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        check("ign_lat", 32'(n + 3), 32'd8);
        check("ign_q", 32'(q), 32'd14);
        check("ign_r", 32'(r), 32'd2);

        // Back-to-back: start in the done cycle (77 / 5 = 15 r 2)
        issue(1'b0, 8'd77, 8'd5);
        check("b2b_busy", 32'(busy), 32'h1);
        check("b2b_done_low", 32'(done), 32'h0);
        wait_done(n);
        check("b2b_lat", 32'(n), 32'd8);
        check("b2b_q", 32'(q), 32'd15);
        check("b2b_r", 32'(r), 32'd2);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN
        issue(1'b0, 8'd100, 8'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_done", 32'(done), 32'h0);
        check("mid_q", 32'(q), 32'h00);
        check("mid_r", 32'(r), 32'h00);
        check("mid_dz", 32'(dz), 32'h0);
        check("mid_v", 32'(v), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // After reset: 255 / 16
        issue(1'b0, 8'd255, 8'd16);
        wait_done(n);
        check("post_lat", 32'(n), 32'd8);
        check("post_q", 32'(q), 32'd15);
        check("post_r", 32'(r), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
